imem_boot_sequencer: RTL and testbench

//  Owns the single write/read port of the pipeline instruction memory (256 x 32, word-addressed by addr[9:2]).

---
 rtl/imem_pkg.sv | 14 +
 rtl/imem_boot_sequencer.sv | 169 ++++++++++++++++
 tb/tb_imem_boot_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and state encoding for the instruction-memory boot sequencer
package imem_pkg;

  localparam int          IMEM_DEPTH  = 256;
  localparam int          IMEM_ADDR_W = $clog2(IMEM_DEPTH);
  localparam logic [31:0] NOP_WORD    = 32'h00000013;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_FILL,
    ST_RUN
  } imem_state_e;

endpackage

// File: rtl/imem_boot_sequencer.sv
// rtl/imem_boot_sequencer.sv - boot loader, NOP filler and fetch port for the instruction memory (optional IMEM_CHECKSUM_EN)
module imem_boot_sequencer
  import imem_pkg::*;
#(
  parameter int          DEPTH    = IMEM_DEPTH,
  parameter int          ADDR_W   = $clog2(DEPTH),
  parameter logic [31:0] NOP_WORD = imem_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  input  logic              reload_req,
  input  logic [31:0]       fetch_addr,
  output logic [31:0]       fetch_instr,
  output logic              fetch_misalign,
  output logic              cpu_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W:0]   words_loaded
`ifdef IMEM_CHECKSUM_EN
  ,
  output logic              chk_ok,
  output logic              chk_err
`endif
);

  // The write pointer carries one extra bit so a completely full image is
  // distinguishable from an empty one after the pointer steps past DEPTH-1.
  localparam int             PTR_W    = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] END_PTR  = PTR_W'(DEPTH);

  imem_state_e      state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] words_q, words_d;
  logic             wr_en;
  logic             in_run;
  logic             run_ok;
  logic             unused_fetch_hi;

`ifdef IMEM_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic [31:0] chk_q, chk_d;
  logic        chk_wait_q, chk_wait_d;
  logic        sum_match;
`endif

  // Next-state logic: image acceptance, NOP padding and reload handling.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    words_d    = words_q;
    load_ready = 1'b0;
    wr_en      = 1'b0;
    mem_wdata  = NOP_WORD;
`ifdef IMEM_CHECKSUM_EN
    sum_d      = sum_q;
    chk_d      = chk_q;
    chk_wait_d = chk_wait_q;
`endif
    case (state_q)
      ST_LOAD: begin
        load_ready = 1'b1;
`ifdef IMEM_CHECKSUM_EN
        if (load_valid && chk_wait_q) begin
          // Checksum word: captured, never written to memory or counted.
          chk_d      = load_data;
          chk_wait_d = 1'b0;
          state_d    = (wr_ptr_q < END_PTR) ? ST_FILL : ST_RUN;
        end else if (load_valid) begin
          wr_en     = 1'b1;
          mem_wdata = load_data;
          wr_ptr_d  = wr_ptr_q + PTR_ONE;
          words_d   = words_q + PTR_ONE;
          sum_d     = sum_q + load_data;
          if (load_last || (wr_ptr_q == LAST_PTR)) begin
            chk_wait_d = 1'b1;
          end
        end
`else
        if (load_valid) begin
          wr_en     = 1'b1;
          mem_wdata = load_data;
          wr_ptr_d  = wr_ptr_q + PTR_ONE;
          words_d   = words_q + PTR_ONE;
          if (load_last || (wr_ptr_q == LAST_PTR)) begin
            state_d = (wr_ptr_q < LAST_PTR) ? ST_FILL : ST_RUN;
          end
        end
`endif
      end
      ST_FILL: begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (wr_ptr_q == LAST_PTR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (reload_req) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          words_d  = '0;
`ifdef IMEM_CHECKSUM_EN
          sum_d      = '0;
          chk_wait_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Output decode: write strobe (suppressed while reset is held), fetch path and stall.
  always_comb begin
    mem_we         = wr_en & ~reset;
    mem_waddr      = wr_ptr_q[ADDR_W-1:0];
    in_run         = (state_q == ST_RUN);
`ifdef IMEM_CHECKSUM_EN
    sum_match      = (sum_q == chk_q);
    run_ok         = in_run & sum_match;
    chk_ok         = run_ok;
    chk_err        = in_run & ~sum_match;
`else
    run_ok         = in_run;
`endif
    cpu_stall      = ~run_ok;
    mem_raddr      = in_run ? fetch_addr[ADDR_W+1:2] : '0;
    fetch_misalign = in_run && (fetch_addr[1:0] != 2'b00);
    fetch_instr    = (in_run && !fetch_misalign) ? mem_rdata : NOP_WORD;
    words_loaded   = words_q;
  end

  // Upper PC bits are deliberately ignored so fetches wrap inside the array.
  assign unused_fetch_hi = ^fetch_addr[31:ADDR_W+2];

  // State register; reset restarts the load at word 0 without touching memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_LOAD;
      wr_ptr_q   <= '0;
      words_q    <= '0;
`ifdef IMEM_CHECKSUM_EN
      sum_q      <= '0;
      chk_q      <= '0;
      chk_wait_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      words_q    <= words_d;
`ifdef IMEM_CHECKSUM_EN
      sum_q      <= sum_d;
      chk_q      <= chk_d;
      chk_wait_q <= chk_wait_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// tb/tb_imem_boot_sequencer.sv - directed self-checking bench for imem_boot_sequencer (IMEM_CHECKSUM_EN aware)
module tb_imem_boot_sequencer;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic        reload_req;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        fetch_misalign;
  logic        cpu_stall;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_raddr;
  logic [31:0] mem_rdata;
  logic [8:0]  words_loaded;
`ifdef IMEM_CHECKSUM_EN
  logic        chk_ok;
  logic        chk_err;
`endif

  logic [31:0] tb_mem [0:255];
  logic [31:0] img [0:255];
  int          wr_count = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  imem_boot_sequencer dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .reload_req(reload_req),
    .fetch_addr(fetch_addr), .fetch_instr(fetch_instr), .fetch_misalign(fetch_misalign),
    .cpu_stall(cpu_stall),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .words_loaded(words_loaded)
`ifdef IMEM_CHECKSUM_EN
    , .chk_ok(chk_ok), .chk_err(chk_err)
`endif
  );

  always @(posedge clk) begin
    if (mem_we) begin
      tb_mem[mem_waddr] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  assign mem_rdata = tb_mem[mem_raddr];

  // Presents img[0..n-1] with `gap` idle cycles before each word; returns #1 after the
  // negedge that follows the final handshake (first FILL cycle if the image is short).
  task automatic load_image(input int n, input int gap, input bit use_last, input logic [31:0] chk_adj);
    logic [31:0] sum = 32'h0;
    for (int i = 0; i < n; i++) begin
      repeat (gap) begin
        @(negedge clk);
        load_valid = 1'b0;
        load_last = 1'b0;
      end
      @(negedge clk);
      load_valid = 1'b1;
      load_data = img[i];
      load_last = use_last && (i == n - 1);
      sum = sum + img[i];
      #1;
      checks++;
      if (load_ready !== 1'b1 || mem_we !== 1'b1 || mem_waddr !== 8'(i) || mem_wdata !== img[i]) begin
        errors++;
        $display("FAIL load_word[%0d]: ready=%0b we=%0b waddr=%0d wdata=%h, expected ready=1 we=1 waddr=%0d wdata=%h",
                 i, load_ready, mem_we, mem_waddr, mem_wdata, i, img[i]);
      end
    end
`ifdef IMEM_CHECKSUM_EN
    @(negedge clk);
    load_valid = 1'b1;
    load_last = 1'b0;
    load_data = sum + chk_adj;
    #1;
    checks++;
    if (load_ready !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL checksum_word: ready=%0b we=%0b, expected ready=1 we=0", load_ready, mem_we);
    end
`else
    if (chk_adj != 32'h0) sum = sum + chk_adj;
`endif
    @(negedge clk);
    load_valid = 1'b0;
    load_last = 1'b0;
    #1;
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload_req = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL reload_still_run: cpu_stall=%0b expected 0", cpu_stall);
    end
    @(negedge clk);
    reload_req = 1'b0;
    #1;
    checks++;
    if (cpu_stall !== 1'b1 || load_ready !== 1'b1 || words_loaded !== 9'd0) begin
      errors++;
      $display("FAIL reload_entry: stall=%0b ready=%0b words=%0d, expected 1 1 0", cpu_stall, load_ready, words_loaded);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    reload_req = 1'b0; fetch_addr = 32'h426;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (cpu_stall !== 1'b1 || load_ready !== 1'b1 || mem_we !== 1'b0 || fetch_misalign !== 1'b0 ||
        fetch_instr !== 32'h00000013 || words_loaded !== 9'd0 || mem_raddr !== 8'd0 || mem_waddr !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: stall=%0b ready=%0b we=%0b mis=%0b instr=%h words=%0d raddr=%0d waddr=%0d, expected 1 1 0 0 00000013 0 0 0",
               cpu_stall, load_ready, mem_we, fetch_misalign, fetch_instr, words_loaded, mem_raddr, mem_waddr);
    end
`ifdef IMEM_CHECKSUM_EN
    checks++;
    if (chk_ok !== 1'b0 || chk_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_chk: ok=%0b err=%0b expected 0 0", chk_ok, chk_err);
    end
`endif
  endtask

  task automatic test_short_image();
    int cyc;
    int bad = 0;
    img[0] = 32'h00A00093; img[1] = 32'h00100113; img[2] = 32'h002081B3; img[3] = 32'h00000213;
    img[4] = 32'h00418233; img[5] = 32'hFFF18193; img[6] = 32'hFE019CE3; img[7] = 32'h00402023;
    img[8] = 32'h00002283; img[9] = 32'hFF5FF06F;
    load_image(10, 0, 1'b1, 32'h0);
    checks++;
    if (mem_we !== 1'b1 || mem_waddr !== 8'd10 || mem_wdata !== 32'h00000013 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_start: we=%0b waddr=%0d wdata=%h ready=%0b, expected 1 10 00000013 0",
               mem_we, mem_waddr, mem_wdata, load_ready);
    end
    cyc = 1;
    while (cpu_stall !== 1'b0 && cyc < 400) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc != 247) begin
      errors++;
      $display("FAIL stall_release_cycle: got %0d expected 247", cyc);
    end
    checks++;
    if (words_loaded !== 9'd10) begin
      errors++;
      $display("FAIL words_loaded_10: got %0d expected 10", words_loaded);
    end
    for (int i = 0; i < 10; i++) if (tb_mem[i] !== img[i]) bad++;
    for (int i = 10; i < 256; i++) if (tb_mem[i] !== 32'h00000013) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL short_image_contents: %0d wrong words, expected 0", bad);
    end
  endtask

  task automatic test_fetch();
    @(negedge clk);
    fetch_addr = 32'h24;
    #1;
    checks++;
    if (fetch_instr !== 32'hFF5FF06F || fetch_misalign !== 1'b0) begin
      errors++;
      $display("FAIL fetch_0x24: instr=%h mis=%0b expected ff5ff06f 0", fetch_instr, fetch_misalign);
    end
    fetch_addr = 32'h426;
    #1;
    checks++;
    if (fetch_instr !== 32'h00000013 || fetch_misalign !== 1'b1) begin
      errors++;
      $display("FAIL fetch_misalign: instr=%h mis=%0b expected 00000013 1", fetch_instr, fetch_misalign);
    end
    fetch_addr = 32'h400;
    #1;
    checks++;
    if (fetch_instr !== 32'h00A00093 || fetch_misalign !== 1'b0) begin
      errors++;
      $display("FAIL fetch_wrap: instr=%h mis=%0b expected 00a00093 0", fetch_instr, fetch_misalign);
    end
  endtask

  task automatic test_full_image();
    int w0;
    pulse_reload();
    for (int i = 0; i < 256; i++) img[i] = 32'hA5000000 | i;
    w0 = wr_count;
    load_image(256, 2, 1'b0, 32'h0);
    checks++;
    if (cpu_stall !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL full_run_next: stall=%0b we=%0b expected 0 0", cpu_stall, mem_we);
    end
    checks++;
    if (wr_count - w0 != 256 || tb_mem[255] !== 32'hA50000FF || tb_mem[0] !== 32'hA5000000) begin
      errors++;
      $display("FAIL full_writes: count=%0d mem0=%h mem255=%h expected 256 a5000000 a50000ff",
               wr_count - w0, tb_mem[0], tb_mem[255]);
    end
    w0 = wr_count;
    load_valid = 1'b1;
    #1;
    checks++;
    if (load_ready !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL run_ignores_load: ready=%0b we=%0b expected 0 0", load_ready, mem_we);
    end
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    checks++;
    if (wr_count != w0 || words_loaded !== 9'd256) begin
      errors++;
      $display("FAIL full_words: writes=%0d words=%0d expected 0 256", wr_count - w0, words_loaded);
    end
  endtask

  task automatic test_reload();
    int cyc;
    int bad = 0;
    pulse_reload();
    img[0] = 32'h11111111; img[1] = 32'h22222222; img[2] = 32'h33333333;
    load_image(3, 0, 1'b1, 32'h0);
    cyc = 1;
    while (cpu_stall !== 1'b0 && cyc < 400) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc != 254 || words_loaded !== 9'd3) begin
      errors++;
      $display("FAIL reload_run: cycles=%0d words=%0d expected 254 3", cyc, words_loaded);
    end
    for (int i = 0; i < 3; i++) if (tb_mem[i] !== img[i]) bad++;
    for (int i = 3; i < 256; i++) if (tb_mem[i] !== 32'h00000013) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reload_contents: %0d wrong words, expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_fill();
    int guard = 0;
    pulse_reload();
    img[0] = 32'hDEADBEEF;
    load_image(1, 0, 1'b1, 32'h0);
    checks++;
    if (mem_we !== 1'b1 || mem_waddr !== 8'd1 || mem_wdata !== 32'h00000013) begin
      errors++;
      $display("FAIL single_word_fill: we=%0b waddr=%0d wdata=%h expected 1 1 00000013", mem_we, mem_waddr, mem_wdata);
    end
    while (mem_waddr !== 8'd100 && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (guard >= 200 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_we: we=%0b guard=%0d expected we=0 within bound", mem_we, guard);
    end
    @(negedge clk);
    reset = 1'b0;
    fetch_addr = 32'h426;
    #1;
    checks++;
    if (cpu_stall !== 1'b1 || load_ready !== 1'b1 || mem_we !== 1'b0 || mem_waddr !== 8'd0 ||
        words_loaded !== 9'd0 || fetch_instr !== 32'h00000013 || fetch_misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fill: stall=%0b ready=%0b we=%0b waddr=%0d words=%0d instr=%h mis=%0b, expected 1 1 0 0 0 00000013 0",
               cpu_stall, load_ready, mem_we, mem_waddr, words_loaded, fetch_instr, fetch_misalign);
    end
    checks++;
    if (tb_mem[0] !== 32'hDEADBEEF || tb_mem[1] !== 32'h00000013) begin
      errors++;
      $display("FAIL reset_mem_kept: mem0=%h mem1=%h expected deadbeef 00000013", tb_mem[0], tb_mem[1]);
    end
  endtask

`ifdef IMEM_CHECKSUM_EN
  task automatic test_checksum();
    int cyc;
    img[0] = 32'd1; img[1] = 32'd2; img[2] = 32'd3;
    load_image(3, 0, 1'b1, 32'h0);
    cyc = 1;
    while (cpu_stall !== 1'b0 && cyc < 400) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc != 254 || chk_ok !== 1'b1 || chk_err !== 1'b0 || words_loaded !== 9'd3) begin
      errors++;
      $display("FAIL checksum_good: cycles=%0d ok=%0b err=%0b words=%0d expected 254 1 0 3",
               cyc, chk_ok, chk_err, words_loaded);
    end
    pulse_reload();
    load_image(3, 0, 1'b1, 32'h1);
    repeat (300) @(negedge clk);
    #1;
    checks++;
    if (chk_err !== 1'b1 || chk_ok !== 1'b0 || cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL checksum_bad: ok=%0b err=%0b stall=%0b expected 0 1 1", chk_ok, chk_err, cpu_stall);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_short_image();
    test_fetch();
    test_full_image();
    test_reload();
    test_reset_mid_fill();
`ifdef IMEM_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
